bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Shares one iterative double-dabble binary-to-BCD core between NUM_REQ requesters. Round-robin arbitration, one conversion in flight, result tagged with requester ID behind a valid/ready output. Sits between counter/measurement producers and the display/UART formatting logic that consumes packed BCD.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BIN_W, 8, binary operand width
BCD_DIGITS, 3, output digits; must satisfy 10^BCD_DIGITS > 2^BIN_W - 1 (elaboration-time check)
ID_W, $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request
req_data  in  NUM_REQ*BIN_W  operands; requester i at [i*BIN_W +: BIN_W]
req_ready  out  NUM_REQ  one-hot grant/accept
res_valid  out  1  result valid
res_ready  in  1  consumer accept
res_bcd  out  4*BCD_DIGITS  packed BCD, digit 0 in [3:0]
res_id  out  ID_W  index of requester that produced res_bcd
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state IDLE, rr pointer 0, req_ready 0, res_valid 0, res_bcd 0, res_id 0, busy 0, core cleared. Reset mid-conversion abandons the operation; no result emitted.
- Controller FSM: IDLE -> CONV -> HOLD -> IDLE.
- IDLE: winner = first i with req_valid[i], searching ptr, ptr+1, ... wrapping modulo NUM_REQ. req_ready[winner] = 1 combinationally; all other bits 0; all 0 if no valid. Acceptance = req_valid[i] & req_ready[i] at the clock edge. On accept: capture operand and ID, pulse core start, ptr <= winner+1 (wrap NUM_REQ-1 -> 0), go CONV.
- req_ready is 0 in CONV and HOLD. Requests are never queued; a requester holds req_valid until accepted. Deasserting req_valid before acceptance is legal and has no effect.
- CONV: core runs; on core done go HOLD with res_valid <= 1, res_bcd/res_id loaded.
- Latency: res_valid rises exactly 2*BIN_W+2 edges after the accepting edge (18 for BIN_W=8).
- HOLD: res_valid, res_bcd, res_id held stable until res_valid & res_ready at an edge; then res_valid <= 0, go IDLE. res_ready low stalls indefinitely. No new grant in the same cycle as the result handshake; next grant earliest one cycle later.
- Min request-to-request spacing: 2*BIN_W+4 cycles with res_ready tied high.
- Core (double dabble): load cycle (bin <= operand, bcd <= 0); then BIN_W iterations of two cycles each: adjust (every digit > 4 gets +3, all digits in parallel, 4-bit wrap impossible by construction), then shift (bcd <= {bcd, bin[MSB]}, bin <= bin << 1); done pulses one cycle after the final shift. Iteration counter width $clog2(BIN_W+1).
- Operand 0 -> all-zero BCD; operand 2^BIN_W-1 -> correct maximum (8'd255 -> 12'h255).
- res_bcd digits always 0..9.

Decomposition:
- Shared package bcd_pkg: controller state enum (IDLE, CONV, HOLD), core state enum (LOAD, ADJ, SHIFT, DONE), constant ADD3 = 4'd3, ADJ_THRESH = 4'd4, function for digit-count check.
- One sub-module: bcd_dd_core (start, operand in; done pulse, bcd out; same clk/rst). Arbiter, pointer and output register stay in bcd_conv_arbiter.

Test Plan:
- Single request: req_valid[2]=1, data 8'd255 -> req_ready=4'b0100 same cycle; res_valid 18 edges after accept; res_bcd=12'h255, res_id=2.
- Value sweep on ch0: 0, 9, 10, 99, 100, 128, 200 -> 12'h000, 009, 010, 099, 100, 128, 200; exhaustive 0..255 vs reference model.
- All four valid continuously from reset, res_ready=1 -> grants in order 0,1,2,3,0; res_id sequence matches; each grant spaced exactly 20 cycles.
- Fairness: ch0 and ch3 both always valid -> grants alternate 0,3,0,3; ch0 never granted twice in a row.
- Backpressure: res_ready=0 for 7 cycles after res_valid -> res_valid/res_bcd/res_id stable, req_ready=0 throughout; handshake on cycle 8, then grant next cycle.
- Reset mid-CONV (rst low 10 cycles after accept of 8'd77) -> all outputs 0 immediately, no res_valid after release; next request 8'd42 returns 12'h042, ptr restarts at 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the shared double-dabble BCD converter.
package bcd_pkg;

  // Controller sequencing: wait for a grant, convert, hold the result.
  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } ctl_state_t;

  // Core sequencing: LOAD doubles as the resting state between conversions.
  typedef enum logic [1:0] {
    LOAD,
    ADJ,
    SHIFT,
    DONE
  } core_state_t;

  localparam logic [3:0] ADD3       = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd4;

  // True when BCD_DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit bcd_digits_ok(input int unsigned bin_w, input int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      pow10 = pow10 * 64'd10;
    end
    max_bin = (64'd1 << bin_w) - 64'd1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// Iterative double-dabble core: one load cycle, then BIN_W adjust/shift pairs.
module bcd_dd_core
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        operand,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  core_state_t      state;
  logic [BIN_W-1:0] bin;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_adj;

  // Add-3 correction on every digit above 4, all digits in parallel.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (bcd[4*d +: 4] > ADJ_THRESH) begin
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + ADD3;
      end
    end
  end

  // Conversion sequencer; done is a one-cycle pulse after the final shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (start) begin
            bin   <= operand;
            bcd   <= '0;
            cnt   <= '0;
            state <= ADJ;
          end
        end
        ADJ: begin
          bcd   <= bcd_adj;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd <= {bcd[BCD_W-2:0], bin[BIN_W-1]};
          bin <= {bin[BIN_W-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ADJ;
          end
        end
        DONE: begin
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin front end sharing one double-dabble core between NUM_REQ requesters.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned BCD_DIGITS = 3,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BIN_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [4*BCD_DIGITS-1:0]    res_bcd,
  output logic [ID_W-1:0]            res_id,
  output logic                       busy
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;

  // Reject digit counts too small to represent the full operand range.
  if (!bcd_digits_ok(BIN_W, BCD_DIGITS)) begin : g_bad_digits
    $error("bcd_conv_arbiter: BCD_DIGITS too small for BIN_W");
  end

  ctl_state_t        state;
  logic [ID_W-1:0]   ptr;
  logic              arb_en;
  logic              core_start;
  logic [BIN_W-1:0]  op_q;
  logic [ID_W-1:0]   id_q;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   idx;
  logic [BIN_W-1:0]  win_data;
  logic [ID_W-1:0]   ptr_next;
  logic              accept;

  logic              core_done;
  logic [BCD_W-1:0]  core_bcd;

  // Round-robin search starting at ptr and wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = ID_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Operand of the current winner.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (win_id == ID_W'(k)) begin
        win_data = req_data[k*BIN_W +: BIN_W];
      end
    end
  end

  // Grant is combinational in IDLE only; arb_en keeps it low while in reset.
  assign req_ready = (state == IDLE && arb_en && win_found) ? (NUM_REQ'(1) << win_id) : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_next  = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  // Controller: grant, run the core, hold the tagged result until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      arb_en     <= 1'b0;
      core_start <= 1'b0;
      op_q       <= '0;
      id_q       <= '0;
      res_valid  <= 1'b0;
      res_bcd    <= '0;
      res_id     <= '0;
      busy       <= 1'b0;
    end else begin
      arb_en     <= 1'b1;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= win_data;
            id_q       <= win_id;
            core_start <= 1'b1;
            ptr        <= ptr_next;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          if (core_done) begin
            res_valid <= 1'b1;
            res_bcd   <= core_bcd;
            res_id    <= id_q;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bcd_dd_core #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .operand (op_q),
    .done    (core_done),
    .bcd     (core_bcd)
  );

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter (NUM_REQ=4, BIN_W=8, BCD_DIGITS=3).
module tb_bcd_conv_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_bcd;
  logic [1:0]  res_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  bcd_conv_arbiter #(
    .NUM_REQ    (4),
    .BIN_W      (8),
    .BCD_DIGITS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bcd   (res_bcd),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          ch;
    logic [7:0]  data;
    logic [11:0] exp_bcd;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t        vecs[8];
  int          g_id[8];
  int          g_cyc[8];
  int          r_id[8];
  logic [11:0] r_bcd[8];
  int          ng;
  int          nr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_reset(input logic [3:0] valid_during);
    @(negedge clk);
    req_valid = valid_during;
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_bcd", 32'(res_bcd), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called just after a negedge with requests driven; waits for a grant.
  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready != 4'b0) begin
        g = req_ready;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("grant_seen", 32'(g != 4'b0), 1);
  endtask

  // Takes the accepting edge, drops requests, counts edges to res_valid.
  task automatic accept_and_wait();
    int lat;
    @(posedge clk);
    #1;
    req_valid = '0;
    check("busy_conv", 32'(busy), 1);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 18);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_res_valid", 32'(res_valid), 0);
    check("hs_busy", 32'(busy), 0);
  endtask

  task automatic single(input int ch, input logic [7:0] d, input logic [11:0] eb, input logic [1:0] eid);
    logic [3:0] g;
    @(negedge clk);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_data[ch*8 +: 8] = d;
    #1;
    wait_grant(g);
    check("grant_onehot", 32'(g), 32'(1) << ch);
    accept_and_wait();
    check("res_bcd", 32'(res_bcd), 32'(eb));
    check("res_id", 32'(res_id), 32'(eid));
    handshake();
  endtask

  // Records grants and results at each negedge until 'want' grants or timeout.
  task automatic monitor(input int want, input int max_cyc);
    ng = 0;
    nr = 0;
    for (int c = 0; c < max_cyc && ng < want; c++) begin
      @(negedge clk);
      #1;
      if (req_ready != 4'b0) begin
        check("mon_onehot", 32'($countones(req_ready)), 1);
        for (int b = 0; b < 4; b++) begin
          if (req_ready[b] && ng < 8) begin
            g_id[ng]  = b;
            g_cyc[ng] = c;
          end
        end
        ng++;
      end
      if (res_valid && nr < 8) begin
        r_id[nr]  = int'(res_id);
        r_bcd[nr] = res_bcd;
        nr++;
      end
    end
  endtask

  initial begin
    logic [3:0] g;
    int         nvalid;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      g_id[i] = -1; g_cyc[i] = -1; r_id[i] = -1; r_bcd[i] = 'x;
    end

    vecs[0] = '{ch: 2, data: 8'd255, exp_bcd: 12'h255, exp_id: 2'd2};
    vecs[1] = '{ch: 0, data: 8'd0,   exp_bcd: 12'h000, exp_id: 2'd0};
    vecs[2] = '{ch: 0, data: 8'd9,   exp_bcd: 12'h009, exp_id: 2'd0};
    vecs[3] = '{ch: 0, data: 8'd10,  exp_bcd: 12'h010, exp_id: 2'd0};
    vecs[4] = '{ch: 0, data: 8'd99,  exp_bcd: 12'h099, exp_id: 2'd0};
    vecs[5] = '{ch: 0, data: 8'd100, exp_bcd: 12'h100, exp_id: 2'd0};
    vecs[6] = '{ch: 0, data: 8'd128, exp_bcd: 12'h128, exp_id: 2'd0};
    vecs[7] = '{ch: 0, data: 8'd200, exp_bcd: 12'h200, exp_id: 2'd0};

    #2;
    do_reset(4'b0000);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      single(vecs[i].ch, vecs[i].data, vecs[i].exp_bcd, vecs[i].exp_id);
    end

    // Exhaustive sweep on ch0 against an arithmetic reference.
    for (int v = 0; v < 256; v++) begin
      single(0, 8'(v), ref_bcd(v), 2'd0);
    end

    // Backpressure: result held 7 cycles, next request granted right after handshake.
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[15:8] = 8'd123;
    res_ready = 1'b0;
    #1;
    wait_grant(g);
    check("bp_grant", 32'(g), 32'h2);
    accept_and_wait();
    check("bp_bcd", 32'(res_bcd), 32'h123);
    check("bp_id", 32'(res_id), 1);
    req_valid = 4'b0100;
    req_data[23:16] = 8'd5;
    for (int s = 1; s <= 7; s++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(res_valid), 1);
      check("bp_hold_bcd", 32'(res_bcd), 32'h123);
      check("bp_hold_id", 32'(res_id), 1);
      check("bp_hold_ready", 32'(req_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_valid", 32'(res_valid), 0);
    check("bp_next_grant", 32'(req_ready), 32'h4);
    accept_and_wait();
    check("bp2_bcd", 32'(res_bcd), 32'h005);
    check("bp2_id", 32'(res_id), 2);
    handshake();

    // All four requesters valid from reset: strict rotation, 20-cycle spacing.
    req_data = {8'd157, 8'd107, 8'd57, 8'd7};
    do_reset(4'b1111);
    monitor(5, 150);
    check("rr_grant_count", 32'(ng), 5);
    for (int i = 0; i < 5; i++) begin
      check("rr_grant_order", 32'(g_id[i]), 32'(i % 4));
    end
    for (int i = 1; i < 5; i++) begin
      check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 20);
    end
    check("rr_result_count", 32'(nr >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      check("rr_res_id", 32'(r_id[i]), 32'(i));
      check("rr_res_bcd", 32'(r_bcd[i]), 32'(ref_bcd(i * 50 + 7)));
    end

    // Fairness between ch0 and ch3.
    req_data = {8'd2, 8'd0, 8'd0, 8'd1};
    do_reset(4'b1001);
    monitor(4, 120);
    check("fair_grant_count", 32'(ng), 4);
    check("fair_g0", 32'(g_id[0]), 0);
    check("fair_g1", 32'(g_id[1]), 3);
    check("fair_g2", 32'(g_id[2]), 0);
    check("fair_g3", 32'(g_id[3]), 3);
    for (int i = 1; i < 4; i++) begin
      check("fair_no_repeat", 32'(g_id[i] != g_id[i-1]), 1);
    end

    // Reset in the middle of a conversion abandons it; pointer restarts at 0.
    req_valid = '0;
    do_reset(4'b0000);
    @(negedge clk);
    req_valid = 4'b0100;
    req_data[23:16] = 8'd77;
    #1;
    wait_grant(g);
    check("mid_grant", 32'(g), 32'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_bcd", 32'(res_bcd), 0);
    check("mid_rst_id", 32'(res_id), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (res_valid) nvalid++;
    end
    check("mid_no_result", 32'(nvalid), 0);
    req_data[7:0]   = 8'd42;
    req_data[31:24] = 8'd99;
    req_valid = 4'b1001;
    #1;
    wait_grant(g);
    check("mid_ptr_restart", 32'(g), 32'h1);
    accept_and_wait();
    check("mid_bcd", 32'(res_bcd), 32'h042);
    check("mid_id", 32'(res_id), 0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
